// File: rtl/maxp_core_pkg.sv
// Shared widths, types and helpers for the max-pool datapath.
package maxp_core_pkg;

  localparam int unsigned DATA_SIZE  = 16;
  localparam int unsigned LOOP_BIT   = 8;
  localparam int unsigned ADDR_BIT   = 16;
  localparam int unsigned RD_LAT_DEF = 1;
  // valid, first, last, final + output address
  localparam int unsigned FLAG_W     = 4 + ADDR_BIT;

  typedef logic [ADDR_BIT-1:0]         addr_t;
  typedef logic [DATA_SIZE-1:0]        size_t;
  typedef logic [LOOP_BIT-1:0]         idx_t;
  typedef logic signed [DATA_SIZE-1:0] data_t;

  // Per-element control that travels alongside the read data.
  typedef struct packed {
    logic  valid;
    logic  first;
    logic  last;
    logic  fin;    // last element of the last window of the last map
    addr_t oaddr;
  } flag_t;

  // Signed max; on a tie the current accumulator is kept.
  function automatic data_t smax(data_t acc, data_t val);
    return (val > acc) ? val : acc;
  endfunction

endpackage

// File: rtl/maxp_core_if.sv
// Index/size inputs plus input-buffer read and output-buffer write ports.
interface maxp_core_if;
  import maxp_core_pkg::*;

  logic  en;
  size_t M;
  size_t nIR;
  size_t nIC;
  size_t nOR;
  size_t nOC;
  size_t MP;
  idx_t  mm;
  idx_t  niro;
  idx_t  nico;
  idx_t  ii;
  idx_t  jj;
  logic  rd_en;
  addr_t rd_addr;
  data_t rd_data;
  logic  wr_en;
  addr_t wr_addr;
  data_t wr_data;
  logic  done;

  modport master (
    output en, M, nIR, nIC, nOR, nOC, MP, mm, niro, nico, ii, jj, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, done
  );

  modport slave (
    input  en, M, nIR, nIC, nOR, nOC, MP, mm, niro, nico, ii, jj, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, done
  );

endinterface

// File: rtl/maxp_dly.sv
// WIDTH x DEPTH shift register with asynchronous active-low clear.
module maxp_dly #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  // Shift every cycle; bubbles travel as whatever is presented on d_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/maxp_core.sv
// Max-pool datapath: turns loop indices into buffer reads, takes the max over
// each MP x MP window and writes one result per window.
// Build option: define MAXP_RELU_EN to clamp negative results to zero.
module maxp_core
  import maxp_core_pkg::*;
#(
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input logic        clk,
  input logic        rst,
  maxp_core_if.slave bus
);

  addr_t in_row;
  addr_t in_col;
  addr_t rd_addr_d;
  addr_t rd_addr_q;
  logic  rd_en_q;
  flag_t flag_d;
  flag_t flag_q;
  data_t acc_q;
  data_t acc_cur;
  data_t wr_data_d;
  data_t wr_data_q;
  addr_t wr_addr_q;
  logic  wr_en_q;
  logic  done_q;
  logic  in_win_q;
  logic  take;

  // Stage 0: address arithmetic and window-position flags.
  always_comb begin
    in_row    = addr_t'(bus.niro) * addr_t'(bus.MP) + addr_t'(bus.ii);
    in_col    = addr_t'(bus.nico) * addr_t'(bus.MP) + addr_t'(bus.jj);
    rd_addr_d = (addr_t'(bus.mm) * addr_t'(bus.nIR) + in_row) * addr_t'(bus.nIC) + in_col;

    flag_d.valid = bus.en;
    flag_d.first = (bus.ii == '0) && (bus.jj == '0);
    flag_d.last  = (size_t'(bus.ii) == bus.MP - size_t'(1)) &&
                   (size_t'(bus.jj) == bus.MP - size_t'(1));
    flag_d.fin   = flag_d.last &&
                   (size_t'(bus.mm)   == bus.M   - size_t'(1)) &&
                   (size_t'(bus.niro) == bus.nOR - size_t'(1)) &&
                   (size_t'(bus.nico) == bus.nOC - size_t'(1));
    flag_d.oaddr = (addr_t'(bus.mm) * addr_t'(bus.nOR) + addr_t'(bus.niro)) *
                   addr_t'(bus.nOC) + addr_t'(bus.nico);
  end

  // Read strobe follows en; the address holds while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_en_q <= bus.en;
      if (bus.en) rd_addr_q <= rd_addr_d;
    end
  end

  // One stage for the read request plus RD_LAT for the buffer itself.
  maxp_dly #(
    .WIDTH (FLAG_W),
    .DEPTH (RD_LAT + 1)
  ) u_dly (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (flag_d),
    .q_o    (flag_q)
  );

  // Running max including the element arriving now, plus the value to write.
  always_comb begin
    acc_cur = flag_q.first ? bus.rd_data : smax(acc_q, bus.rd_data);
    // Stray tail elements of a window cut short by reset are ignored.
    take    = flag_q.valid && (flag_q.first || in_win_q);
`ifdef MAXP_RELU_EN
    wr_data_d = acc_cur[DATA_SIZE-1] ? '0 : acc_cur;
`else
    wr_data_d = acc_cur;
`endif
  end

  // Accumulator, window tracking and single-cycle write/done pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      in_win_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= take && flag_q.last;
      done_q  <= take && flag_q.last && flag_q.fin;
      if (take) begin
        acc_q    <= acc_cur;
        in_win_q <= !flag_q.last;
      end
      if (take && flag_q.last) begin
        wr_addr_q <= flag_q.oaddr;
        wr_data_q <= wr_data_d;
      end
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.done    = done_q;

endmodule
